// File: rtl/edge_event_capture.sv
// Edge event capture: synchronises and glitch-filters asynchronous inputs,
// detects per-channel rise/fall edges, and keeps sticky flags and counters.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   a_in[N_CH]     : asynchronous raw inputs
//   mode[2*N_CH]   : per-channel edge select (00 none, 01 rise, 10 fall, 11 both)
//   irq_en[N_CH]   : per-channel interrupt enable
//   clr[N_CH]      : per-channel write-one-clear of pending flag and counter
//   level[N_CH]    : filtered synchronised level
//   edge_pulse     : one-cycle pulse per qualifying edge
//   pending        : sticky event flag
//   irq            : OR over channels of pending & irq_en
//   evt_cnt        : saturating event counters, channel i at [i*CNT_W +: CNT_W]
module edge_event_capture #(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_CH-1:0]       a_in,
   input  logic [2*N_CH-1:0]     mode,
   input  logic [N_CH-1:0]       irq_en,
   input  logic [N_CH-1:0]       clr,
   output logic [N_CH-1:0]       level,
   output logic [N_CH-1:0]       edge_pulse,
   output logic [N_CH-1:0]       pending,
   output logic                  irq,
   output logic [N_CH*CNT_W-1:0] evt_cnt
);

   localparam int             FW      = $clog2(FILTER_LEN + 1);
   localparam logic [FW-1:0]  F_LAST  = FW'(FILTER_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q [N_CH];
   logic [FW-1:0]          filt_q [N_CH];
   logic [CNT_W-1:0]       cnt_q  [N_CH];
   // Previous filtered level; edge detect compares level against it so the
   // pulse appears the cycle after level itself moves.
   logic [N_CH-1:0]        level_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            sync_q[i] <= '0;
            filt_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         level      <= '0;
         level_d    <= '0;
         edge_pulse <= '0;
         pending    <= '0;
      end else begin
         level_d <= level;
         for (int i = 0; i < N_CH; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], a_in[i]};

            if (sync_q[i][SYNC_STAGES-1] == level[i]) begin
               filt_q[i] <= '0;
            end else if (filt_q[i] == F_LAST) begin
               filt_q[i] <= '0;
               level[i]  <= sync_q[i][SYNC_STAGES-1];
            end else begin
               filt_q[i] <= filt_q[i] + 1'b1;
            end

            edge_pulse[i] <= (level[i] & ~level_d[i] & mode[2*i])
                           | (~level[i] & level_d[i] & mode[2*i+1]);

            // A new event beats a same-cycle clear and restarts the count.
            if (edge_pulse[i]) begin
               pending[i] <= 1'b1;
               if (clr[i])
                  cnt_q[i] <= CNT_W'(1);
               else if (cnt_q[i] != CNT_MAX)
                  cnt_q[i] <= cnt_q[i] + 1'b1;
            end else if (clr[i]) begin
               pending[i] <= 1'b0;
               cnt_q[i]   <= '0;
            end
         end
      end
   end

   assign irq = |(pending & irq_en);

   for (genvar g = 0; g < N_CH; g++) begin : g_cnt
      assign evt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end

endmodule

// File: tb/tb_edge_event_capture.sv
// Self-checking bench for edge_event_capture (default parameters):
// table-driven scenarios through a scoreboard plus hand-written corner cases.
module tb_edge_event_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  a_in;
   logic [7:0]  mode;
   logic [3:0]  irq_en;
   logic [3:0]  clr;
   logic [3:0]  level;
   logic [3:0]  edge_pulse;
   logic [3:0]  pending;
   logic        irq;
   logic [31:0] evt_cnt;

   int tests = 0;
   int fails = 0;

   edge_event_capture dut (
      .clk        (clk),
      .reset      (reset),
      .a_in       (a_in),
      .mode       (mode),
      .irq_en     (irq_en),
      .clr        (clr),
      .level      (level),
      .edge_pulse (edge_pulse),
      .pending    (pending),
      .irq        (irq),
      .evt_cnt    (evt_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         ch;
      logic [1:0] md;
      int         w;
      logic       exp_pend;
      logic [7:0] exp_cnt;
   } vec_t;

   typedef struct {
      logic [3:0]  pend;
      logic [31:0] cnt;
      logic        irq;
   } sb_t;

   vec_t vecs [7];
   sb_t  sbq  [$];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      a_in  = '0;
      clr   = '0;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      sb_t e;
      sb_t got;
      int  found;
      int  npulse;

      vecs[0] = '{0, 2'b01, 10, 1'b1, 8'd1};
      vecs[1] = '{1, 2'b01,  2, 1'b0, 8'd0};
      vecs[2] = '{1, 2'b01,  3, 1'b1, 8'd1};
      vecs[3] = '{2, 2'b10, 10, 1'b1, 8'd1};
      vecs[4] = '{3, 2'b11, 10, 1'b1, 8'd2};
      vecs[5] = '{0, 2'b00, 10, 1'b0, 8'd0};
      vecs[6] = '{2, 2'b11,  1, 1'b0, 8'd0};

      reset  = 1'b1;
      a_in   = '0;
      mode   = '0;
      irq_en = '0;
      clr    = '0;
      tick(2);
      chk("reset_level",   {28'd0, level}, 32'd0);
      chk("reset_pending", {28'd0, pending}, 32'd0);
      chk("reset_cnt",     evt_cnt, 32'd0);
      chk("reset_irq",     {31'd0, irq}, 32'd0);
      reset = 1'b0;

      // Latency: level after 5 edges, pulse at edge 6 only.
      mode      = 8'b01;
      irq_en    = 4'b0001;
      a_in[0]   = 1'b1;
      tick(4);
      chk("lat_level_e4", {31'd0, level[0]}, 32'd0);
      tick(1);
      chk("lat_level_e5", {31'd0, level[0]}, 32'd1);
      chk("lat_pulse_e5", {31'd0, edge_pulse[0]}, 32'd0);
      tick(1);
      chk("lat_pulse_e6", {28'd0, edge_pulse}, 32'd1);
      tick(1);
      chk("lat_pulse_e7", {28'd0, edge_pulse}, 32'd0);
      chk("lat_pending",  {28'd0, pending}, 32'd1);
      chk("lat_cnt",      evt_cnt, 32'd1);
      chk("lat_irq",      {31'd0, irq}, 32'd1);

      // Table scenarios through the scoreboard.
      irq_en = 4'b0101;
      for (int v = 0; v < 7; v++) begin
         do_reset();
         mode = '0;
         mode[2*vecs[v].ch +: 2] = vecs[v].md;
         e.pend = 4'(vecs[v].exp_pend) << vecs[v].ch;
         e.cnt  = 32'(vecs[v].exp_cnt) << (8 * vecs[v].ch);
         e.irq  = vecs[v].exp_pend & irq_en[vecs[v].ch];
         sbq.push_back(e);
         a_in[vecs[v].ch] = 1'b1;
         tick(vecs[v].w);
         a_in = '0;
         tick(12);
         got = sbq.pop_front();
         chk($sformatf("vec%0d_pending", v), {28'd0, pending}, {28'd0, got.pend});
         chk($sformatf("vec%0d_cnt", v), evt_cnt, got.cnt);
         chk($sformatf("vec%0d_irq", v), {31'd0, irq}, {31'd0, got.irq});
      end

      // Saturation: 300 full toggles in both-edge mode.
      do_reset();
      mode = 8'b11 << 4;
      for (int t = 0; t < 300; t++) begin
         a_in[2] = 1'b1;
         tick(4);
         a_in[2] = 1'b0;
         tick(4);
      end
      tick(10);
      chk("sat_cnt2",    {24'd0, evt_cnt[23:16]}, 32'd255);
      chk("sat_pending", {28'd0, pending}, 32'b0100);

      // Clear colliding with a pulse: set wins, count restarts at 1.
      do_reset();
      mode    = 8'b11 << 6;
      a_in[3] = 1'b1;
      tick(10);
      a_in[3] = 1'b0;
      found   = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
         tick(1);
         if (edge_pulse[3]) found = 1;
      end
      chk("clr_pulse_seen", found, 1);
      clr[3] = 1'b1;
      tick(1);
      chk("clr_coll_pending", {31'd0, pending[3]}, 32'd1);
      chk("clr_coll_cnt",     {24'd0, evt_cnt[31:24]}, 32'd1);
      tick(1);
      chk("clr_alone_pending", {31'd0, pending[3]}, 32'd0);
      chk("clr_alone_cnt",     {24'd0, evt_cnt[31:24]}, 32'd0);
      clr = '0;

      // Inputs high through reset: all channels rise together.
      mode  = 8'b01010101;
      reset = 1'b1;
      a_in  = 4'hF;
      tick(3);
      reset = 1'b0;
      tick(5);
      chk("rst_hi_pulse_e5", {28'd0, edge_pulse}, 32'd0);
      tick(1);
      chk("rst_hi_pulse_e6", {28'd0, edge_pulse}, 32'hF);
      tick(1);
      chk("rst_hi_pending",  {28'd0, pending}, 32'hF);
      chk("rst_hi_cnt",      evt_cnt, 32'h01010101);

      // Reset in the middle of a filter count.
      do_reset();
      mode    = 8'b01;
      a_in[0] = 1'b1;
      tick(3);
      reset = 1'b1;
      a_in  = '0;
      tick(1);
      reset = 1'b0;
      chk("midrst_outs", {level, edge_pulse, pending, 3'd0, irq, evt_cnt[15:0]}, 32'd0);
      npulse = 0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         if (edge_pulse != 0) npulse++;
      end
      chk("midrst_no_pulse", npulse, 0);
      chk("midrst_cnt",      evt_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
